vend_ctrl: RTL and testbench
============================

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter N_ITEMS, default 8: number of item slots, 2..16.
REQ-002 SHALL have parameter SEL_W, default 3: selection width, 2^SEL_W >= N_ITEMS.
REQ-003 SHALL have parameter MONEY_W, default 8: credit, coin and change width.
REQ-004 SHALL have parameter PRICE_STEP, default 2: price(i) = (i+1)*PRICE_STEP, must fit MONEY_W.
REQ-005 SHALL have parameter STOCK_W, default 4, and STOCK_INIT, default 4: per-item stock width and reset stock.
REQ-006 SHALL have parameter TIMEOUT, default 100: inactivity limit in COLLECT, in cycles.
REQ-007 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-008 SHALL have ports: rst  in  1  synchronous reset, active-high.
REQ-009 SHALL have ports: coin_valid  in  1  coin present this cycle; coin_value  in  MONEY_W  coin amount.
REQ-010 SHALL have ports: sel_valid  in  1  selection strobe; sel  in  SEL_W  item index; cancel  in  1  refund request.
REQ-011 SHALL have ports: restock_valid  in  1; restock_item  in  SEL_W  add one unit to that slot.
REQ-012 SHALL have ports: vend_valid  out  1  one-cycle dispense pulse; vend_item  out  SEL_W  dispensed index.
REQ-013 SHALL have ports: change_valid  out  1  one-cycle pulse; change  out  MONEY_W  amount returned.
REQ-014 SHALL have ports: credit  out  MONEY_W  current credit; available  out  N_ITEMS  bit i = stock(i) > 0.
REQ-015 SHALL have ports: coin_reject  out  1  pulse; err_valid  out  1  pulse; err_code  out  2  0 NO_CREDIT, 1 INVALID, 2 SOLD_OUT, 3 INSUFFICIENT.

Function
REQ-016 SHALL implement states IDLE, COLLECT, DISPENSE, REFUND; all outputs registered.
REQ-017 IDLE: coin_valid -> credit = coin_value, go COLLECT; sel_valid alone -> err NO_CREDIT, stay IDLE.
REQ-018 COLLECT: coin_valid adds coin_value to credit; if sum exceeds 2^MONEY_W-1, coin_reject pulses next cycle, credit unchanged.
REQ-019 COLLECT sel_valid priority: sel >= N_ITEMS -> INVALID; stock 0 -> SOLD_OUT; credit < price -> INSUFFICIENT; else go DISPENSE.
REQ-020 Error pulses: one cycle, the cycle after the offending strobe; state and credit unchanged.
REQ-021 DISPENSE, one cycle, entered the cycle after the accepted sel: vend_valid=1, vend_item=sel, change_valid=1, change=credit-price (0 allowed), stock(sel) decremented; credit cleared; next state IDLE.
REQ-022 REFUND, one cycle: change_valid=1, change=credit, credit cleared; next state IDLE.
REQ-023 Priorities within COLLECT: cancel > coin_valid > sel_valid. With cancel, go REFUND and reject any same-cycle coin. With coin plus sel, add the coin and ignore sel with no error.
REQ-024 In DISPENSE and REFUND: coin_valid -> coin_reject; sel_valid and cancel ignored.
REQ-025 Timeout: counter cleared on IDLE->COLLECT and on every coin_valid or sel_valid in COLLECT; reaching TIMEOUT consecutive idle cycles -> REFUND.
REQ-026 Restock accepted in any state; stock saturates at 2^STOCK_W-1; restock_item >= N_ITEMS is ignored.
REQ-027 Restock and dispense on the same item in the same cycle: net stock change 0.
REQ-028 available SHALL reflect stock registers with one-cycle latency; vend_valid and change_valid never assert in the same cycle as an err_valid.

Reset
REQ-029 rst SHALL be sampled on clk rising edge only; it overrides all inputs, including mid-DISPENSE/REFUND, with no pulse emitted and credit discarded.
REQ-030 After reset: state IDLE; credit 0; all pulse outputs 0; vend_item 0; change 0; err_code 0; timer 0; every stock = STOCK_INIT; available all ones if STOCK_INIT > 0.

Verification
REQ-031 Defaults. Coins 5 then 3, then sel=2 (price 6): credit reaches 8, then vend_valid with vend_item=2 and change=2 in one cycle; stock(2) becomes 3.
REQ-032 Coin 3, then sel=4 (price 10): err INSUFFICIENT and credit stays 3. Then cancel: change_valid with change=3, credit 0, state IDLE.
REQ-033 Drain item 0 with 4 purchases: available[0]=0. A fifth selection gives SOLD_OUT. restock item 0: available[0]=1 the next cycle.
REQ-034 Coin 7, then TIMEOUT idle cycles: change_valid with change=7 exactly at the timeout. A coin at cycle TIMEOUT-1 restarts the count instead.
REQ-035 Credit 250 plus coin 10: coin_reject and credit 250. Same-cycle coin+cancel: coin rejected, refund of the prior credit. sel=9 with N_ITEMS=8: INVALID.
REQ-036 rst asserted during DISPENSE: no vend_valid; all outputs at reset values next cycle; stock restored to STOCK_INIT.

Source files
------------

// File: rtl/vend_ctrl.sv
// Vending-machine controller: coin credit, item selection with per-slot stock,
// change/refund, inactivity timeout and restocking. All outputs are registered.
module vend_ctrl #(
    parameter int unsigned N_ITEMS    = 8,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned MONEY_W    = 8,
    parameter int unsigned PRICE_STEP = 2,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 4,
    parameter int unsigned TIMEOUT    = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin_value,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   sel,
    input  logic               cancel,
    input  logic               restock_valid,
    input  logic [SEL_W-1:0]   restock_item,
    output logic               vend_valid,
    output logic [SEL_W-1:0]   vend_item,
    output logic               change_valid,
    output logic [MONEY_W-1:0] change,
    output logic [MONEY_W-1:0] credit,
    output logic [N_ITEMS-1:0] available,
    output logic               coin_reject,
    output logic               err_valid,
    output logic [1:0]         err_code
);

    typedef enum logic [1:0] {StIdle, StCollect, StDispense, StRefund} state_e;

    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] ErrNoCredit = 2'd0;
    localparam logic [1:0] ErrInvalid  = 2'd1;
    localparam logic [1:0] ErrSoldOut  = 2'd2;
    localparam logic [1:0] ErrInsuff   = 2'd3;
    localparam logic [STOCK_W-1:0] StockMax = '1;

    state_e state_q, state_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [MONEY_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [STOCK_W-1:0] stock_q [N_ITEMS];
    logic [STOCK_W-1:0] stock_d [N_ITEMS];
    logic [N_ITEMS-1:0] avail_q, avail_d;
    logic               vend_valid_q, vend_valid_d, change_valid_q, change_valid_d;
    logic [SEL_W-1:0]   vend_item_q, vend_item_d;
    logic [MONEY_W-1:0] change_q, change_d;
    logic               coin_reject_q, coin_reject_d, err_valid_q, err_valid_d;
    logic [1:0]         err_code_q, err_code_d;

    function automatic logic [MONEY_W-1:0] price_of(input logic [SEL_W-1:0] idx);
        return MONEY_W'((32'(idx) + 32'd1) * PRICE_STEP);
    endfunction

    logic               sel_in_range, sel_ok, timed_out;
    logic [SEL_W-1:0]   sel_idx;
    logic [MONEY_W:0]   coin_sum;

    assign sel_in_range = 32'(sel) < N_ITEMS;
    // Out-of-range selections read slot 0; the INVALID check wins before stock is used.
    assign sel_idx   = sel_in_range ? sel : '0;
    assign sel_ok    = sel_in_range && (stock_q[sel_idx] != '0) && (credit_q >= price_of(sel_idx));
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
    assign timed_out = timer_q == TimerW'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (coin_valid) state_d = StCollect;
            StCollect: begin
                if (cancel)                      state_d = StRefund;
                else if (coin_valid)             state_d = StCollect;
                else if (sel_valid)              state_d = sel_ok ? StDispense : StCollect;
                else if (timed_out)              state_d = StRefund;
            end
            StDispense, StRefund: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        timer_d        = timer_q;
        credit_d       = credit_q;
        sel_d          = sel_q;
        vend_valid_d   = 1'b0;
        vend_item_d    = vend_item_q;
        change_valid_d = 1'b0;
        change_d       = change_q;
        coin_reject_d  = 1'b0;
        err_valid_d    = 1'b0;
        err_code_d     = err_code_q;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (coin_valid) begin
                    credit_d = coin_value;
                end else if (sel_valid) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ErrNoCredit;
                end
            end
            StCollect: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                end else if (coin_valid) begin
                    timer_d = '0;
                    if (coin_sum[MONEY_W]) coin_reject_d = 1'b1;
                    else                   credit_d = coin_sum[MONEY_W-1:0];
                end else if (sel_valid) begin
                    timer_d = '0;
                    if (!sel_in_range) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ErrInvalid;
                    end else if (stock_q[sel_idx] == '0) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ErrSoldOut;
                    end else if (credit_q < price_of(sel_idx)) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ErrInsuff;
                    end else begin
                        sel_d = sel;
                    end
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StDispense: begin
                vend_valid_d   = 1'b1;
                vend_item_d    = sel_q;
                change_valid_d = 1'b1;
                change_d       = credit_q - price_of(sel_q);
                credit_d       = '0;
                coin_reject_d  = coin_valid;
            end
            StRefund: begin
                change_valid_d = 1'b1;
                change_d       = credit_q;
                credit_d       = '0;
                coin_reject_d  = coin_valid;
            end
            default: ;
        endcase
    end

    // A restock and a dispense on the same slot cancel out, even at saturation.
    always_comb begin
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            logic dec, inc;
            dec = (state_q == StDispense) && (sel_q == SEL_W'(i));
            inc = restock_valid && (restock_item == SEL_W'(i));
            stock_d[i] = stock_q[i];
            if (dec && !inc)                             stock_d[i] = stock_q[i] - 1'b1;
            else if (inc && !dec && stock_q[i] != StockMax) stock_d[i] = stock_q[i] + 1'b1;
            avail_d[i] = stock_d[i] != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q        <= '0;
            credit_q       <= '0;
            sel_q          <= '0;
            avail_q        <= {N_ITEMS{STOCK_INIT != 0}};
            vend_valid_q   <= 1'b0;
            vend_item_q    <= '0;
            change_valid_q <= 1'b0;
            change_q       <= '0;
            coin_reject_q  <= 1'b0;
            err_valid_q    <= 1'b0;
            err_code_q     <= '0;
            for (int unsigned i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            timer_q        <= timer_d;
            credit_q       <= credit_d;
            sel_q          <= sel_d;
            avail_q        <= avail_d;
            vend_valid_q   <= vend_valid_d;
            vend_item_q    <= vend_item_d;
            change_valid_q <= change_valid_d;
            change_q       <= change_d;
            coin_reject_q  <= coin_reject_d;
            err_valid_q    <= err_valid_d;
            err_code_q     <= err_code_d;
            for (int unsigned i = 0; i < N_ITEMS; i++) stock_q[i] <= stock_d[i];
        end
    end

    assign vend_valid   = vend_valid_q;
    assign vend_item    = vend_item_q;
    assign change_valid = change_valid_q;
    assign change       = change_q;
    assign credit       = credit_q;
    assign available    = avail_q;
    assign coin_reject  = coin_reject_q;
    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: expected output pulses are queued as stimulus is
// driven and checked by a monitor; levels are checked inline.
module tb_vend_ctrl;

    localparam int unsigned T = 100;

    logic       clk = 1'b0;
    logic       rst, coin_valid, sel_valid, cancel, restock_valid;
    logic [7:0] coin_value;
    logic [3:0] sel, restock_item;
    logic       vend_valid, change_valid, coin_reject, err_valid;
    logic [3:0] vend_item;
    logic [7:0] change, credit, available;
    logic [1:0] err_code;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct packed {
        logic       vv;
        logic [3:0] vi;
        logic       cv;
        logic [7:0] ch;
        logic       cr;
        logic       ev;
        logic [1:0] ec;
    } ev_t;

    ev_t exp_q[$];

    vend_ctrl #(.SEL_W(4)) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
        .restock_valid(restock_valid), .restock_item(restock_item),
        .vend_valid(vend_valid), .vend_item(vend_item),
        .change_valid(change_valid), .change(change), .credit(credit),
        .available(available), .coin_reject(coin_reject),
        .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Pulse monitor: every cycle with any pulse must match the next queued event.
    always @(negedge clk) begin
        if (!rst && (vend_valid || change_valid || coin_reject || err_valid)) begin
            ev_t obs, want;
            obs.vv = vend_valid;   obs.vi = vend_valid ? vend_item : 4'd0;
            obs.cv = change_valid; obs.ch = change_valid ? change : 8'd0;
            obs.cr = coin_reject;
            obs.ev = err_valid;    obs.ec = err_valid ? err_code : 2'd0;
            want = '0;
            if (exp_q.size() > 0) want = exp_q.pop_front();
            n_cmp++;
            assert (obs === want) else begin
                n_mis++;
                $error("FAIL event: got vend=%0d/%0d change=%0d/%0d rej=%0d err=%0d/%0d want vend=%0d/%0d change=%0d/%0d rej=%0d err=%0d/%0d",
                       obs.vv, obs.vi, obs.cv, obs.ch, obs.cr, obs.ev, obs.ec,
                       want.vv, want.vi, want.cv, want.ch, want.cr, want.ev, want.ec);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_mis++;
            $error("FAIL %s: got %0d want %0d", tag, obs, want);
        end
    endtask

    task automatic push(input logic vv, input logic [3:0] vi, input logic cv,
                        input logic [7:0] ch, input logic cr, input logic ev,
                        input logic [1:0] ec);
        ev_t e;
        e.vv = vv; e.vi = vi; e.cv = cv; e.ch = ch; e.cr = cr; e.ev = ev; e.ec = ec;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [7:0] v);
        coin_valid = 1'b1; coin_value = v;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic select(input logic [3:0] s);
        sel_valid = 1'b1; sel = s;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic buy(input logic [3:0] s, input logic [7:0] pay, input logic [7:0] chg);
        coin(pay);
        push(1, s, 1, chg, 0, 0, 0);
        select(s);
        tick();
        tick();
    endtask

    task automatic wait_change(input string tag, input int want_n);
        int n;
        n = 0;
        while (change_valid !== 1'b1 && n < 3 * T) begin
            tick();
            n++;
        end
        chk(tag, n, want_n);
    endtask

    initial begin
        rst = 1'b1; coin_valid = 0; coin_value = 0; sel_valid = 0; sel = 0;
        cancel = 0; restock_valid = 0; restock_item = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_credit", credit, 0);
        chk("rst_avail", available, 8'hFF);
        chk("rst_pulses", {vend_valid, change_valid, coin_reject, err_valid}, 0);
        chk("rst_vend_item", vend_item, 0);
        chk("rst_change", change, 0);
        chk("rst_err_code", err_code, 0);

        // Selection with no credit
        push(0, 0, 0, 0, 0, 1, 2'd0);
        select(4'd1);
        tick();

        // Coins 5+3, buy item 2 (price 6)
        coin(8'd5);
        chk("credit_5", credit, 5);
        coin(8'd3);
        chk("credit_8", credit, 8);
        push(1, 4'd2, 1, 8'd2, 0, 0, 0);
        select(4'd2);
        tick(); tick();
        chk("credit_after_vend", credit, 0);
        chk("avail_2", available[2], 1);

        // Insufficient credit, then cancel
        coin(8'd3);
        push(0, 0, 0, 0, 0, 1, 2'd3);
        select(4'd4);
        chk("credit_insuff", credit, 3);
        push(0, 0, 1, 8'd3, 0, 0, 0);
        do_cancel();
        tick(); tick();
        chk("credit_refund", credit, 0);
        push(0, 0, 0, 0, 0, 1, 2'd0);
        select(4'd0);
        tick();

        // Drain item 0, sold out, restock
        for (int i = 0; i < 4; i++) buy(4'd0, 8'd2, 8'd0);
        chk("avail0_drained", available[0], 0);
        coin(8'd2);
        push(0, 0, 0, 0, 0, 1, 2'd2);
        select(4'd0);
        restock_valid = 1'b1; restock_item = 4'd0;
        tick();
        restock_valid = 1'b0;
        chk("avail0_restock", available[0], 1);
        push(0, 0, 1, 8'd2, 0, 0, 0);
        do_cancel();
        tick(); tick();

        // Dispense and restock of the same slot in one cycle: stock stays 1
        coin(8'd2);
        push(1, 4'd0, 1, 8'd0, 0, 0, 0);
        select(4'd0);
        restock_valid = 1'b1; restock_item = 4'd0;
        tick();
        restock_valid = 1'b0;
        tick();
        chk("avail0_net_zero", available[0], 1);

        // Timeout refund exactly after TIMEOUT idle cycles
        coin(8'd7);
        push(0, 0, 1, 8'd7, 0, 0, 0);
        wait_change("timeout_cycles", T + 1);
        tick(); tick();

        // A coin at idle cycle TIMEOUT-1 restarts the count
        coin(8'd7);
        for (int i = 0; i < T - 1; i++) tick();
        coin(8'd1);
        chk("credit_restart", credit, 8);
        push(0, 0, 1, 8'd8, 0, 0, 0);
        wait_change("timeout_restart", T + 1);
        tick(); tick();

        // Overflow rejection and exact fill to the maximum credit
        coin(8'd250);
        push(0, 0, 0, 0, 1, 0, 0);
        coin(8'd10);
        chk("credit_overflow", credit, 250);
        coin(8'd5);
        chk("credit_max", credit, 255);
        push(0, 0, 0, 0, 1, 0, 0);
        push(0, 0, 1, 8'd255, 0, 0, 0);
        coin_valid = 1'b1; coin_value = 8'd1; cancel = 1'b1;
        tick();
        coin_valid = 1'b0; cancel = 1'b0;
        tick(); tick();
        chk("credit_cancel_coin", credit, 0);

        // Invalid index, coin with selection, exact-price purchase
        coin(8'd20);
        push(0, 0, 0, 0, 0, 1, 2'd1);
        select(4'd9);
        chk("credit_invalid", credit, 20);
        coin_valid = 1'b1; coin_value = 8'd2; sel_valid = 1'b1; sel = 4'd0;
        tick();
        coin_valid = 1'b0; sel_valid = 1'b0;
        chk("credit_coin_sel", credit, 22);
        push(0, 0, 1, 8'd22, 0, 0, 0);
        do_cancel();
        tick(); tick();
        buy(4'd7, 8'd16, 8'd0);

        // Coin during DISPENSE is rejected in the same pulse cycle as the vend
        coin(8'd4);
        push(1, 4'd1, 1, 8'd0, 1, 0, 0);
        select(4'd1);
        coin(8'd3);
        tick();
        chk("credit_after_rej", credit, 0);

        // Reset in the middle of DISPENSE restores all state
        buy(4'd1, 8'd4, 8'd0);
        buy(4'd1, 8'd4, 8'd0);
        coin(8'd4);
        select(4'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_credit", credit, 0);
        chk("rst2_pulses", {vend_valid, change_valid, coin_reject, err_valid}, 0);
        chk("rst2_vend_item", vend_item, 0);
        chk("rst2_avail", available, 8'hFF);
        for (int i = 0; i < 4; i++) buy(4'd1, 8'd4, 8'd0);
        chk("avail1_drained", available[1], 0);

        tick(); tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
